// File: rtl/ram2_arbiter_pkg.sv
// Shared state encoding and strobe polarity for the RAM2 arbiter.
package ram2_arbiter_pkg;

  typedef enum logic [1:0] {
    R2_IDLE    = 2'd0,
    R2_ACCESS  = 2'd1,
    R2_RECOVER = 2'd2
  } r2_state_t;

  localparam logic STROBE_ON  = 1'b0;
  localparam logic STROBE_OFF = 1'b1;

  function automatic logic strobe_level(input logic active);
    return active ? STROBE_ON : STROBE_OFF;
  endfunction

endpackage

// File: rtl/ram2_ibuf.sv
// One-entry instruction buffer: filled on each fetch capture, invalidated by a store to its tag.
module ram2_ibuf #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fill,
  input  logic [ADDR_W-1:0] fill_tag,
  input  logic [DATA_W-1:0] fill_data,
  input  logic              inval,
  input  logic [ADDR_W-1:0] inval_addr,
  input  logic [ADDR_W-1:0] look_addr,
  output logic              hit,
  output logic [DATA_W-1:0] data
);

  logic              valid;
  logic [ADDR_W-1:0] tag;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= 1'b0;
      tag   <= '0;
      data  <= '0;
    end else if (fill) begin
      valid <= 1'b1;
      tag   <= fill_tag;
      data  <= fill_data;
    end else if (inval && (inval_addr == tag)) begin
      valid <= 1'b0;
    end
  end

  assign hit = valid && (tag == look_addr);

endmodule

// File: rtl/ram2_arbiter.sv
// Arbitrates the single-port RAM2 SRAM between IF and MEM; MEM wins ties.
// Optional instruction buffer enabled with `define RAM2_IBUF_EN.
module ram2_arbiter
  import ram2_arbiter_pkg::*;
#(
  parameter int ADDR_W   = 18,
  parameter int DATA_W   = 16,
  parameter int WAIT_CYC = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_data,
  output logic              if_ack,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ack,
  output logic              stall_req,
  output logic [ADDR_W-1:0] ram2_addr,
  output logic [DATA_W-1:0] ram2_dq_o,
  input  logic [DATA_W-1:0] ram2_dq_i,
  output logic              ram2_dq_oe,
  output logic              ram2_ce_n,
  output logic              ram2_oe_n,
  output logic              ram2_we_n
);

  localparam int CNT_W = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYC - 1);

  r2_state_t         state, state_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic              cur_mem, cur_mem_nx, cur_we, cur_we_nx;
  logic [ADDR_W-1:0] addr_nx;
  logic [DATA_W-1:0] dq_o_nx, if_data_nx, mem_rdata_nx;
  logic              dq_oe_nx, ce_n_nx, oe_n_nx, we_n_nx, if_ack_nx, mem_ack_nx;
  logic              mem_go, if_go, ibuf_hit;
  logic [DATA_W-1:0] ibuf_data;

  // A port whose ack is high this cycle is excluded, which gives the RECOVER exclusion rule.
  assign mem_go    = mem_req && !mem_ack;
  assign if_go     = if_req && !if_ack;
  assign stall_req = (if_req && !if_ack) || (mem_req && !mem_ack);

`ifdef RAM2_IBUF_EN
  logic ibuf_fill, ibuf_inval;
  assign ibuf_fill  = (state == R2_ACCESS) && (cnt == CNT_LAST) && !cur_mem;
  assign ibuf_inval = (state != R2_ACCESS) && mem_go && mem_we;

  ram2_ibuf #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ibuf (
    .clk        (clk),
    .rst        (rst),
    .fill       (ibuf_fill),
    .fill_tag   (ram2_addr),
    .fill_data  (ram2_dq_i),
    .inval      (ibuf_inval),
    .inval_addr (mem_addr),
    .look_addr  (if_addr),
    .hit        (ibuf_hit),
    .data       (ibuf_data)
  );
`else
  assign ibuf_hit  = 1'b0;
  assign ibuf_data = '0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= R2_IDLE;
      cnt        <= '0;
      cur_mem    <= 1'b0;
      cur_we     <= 1'b0;
      ram2_addr  <= '0;
      ram2_dq_o  <= '0;
      ram2_dq_oe <= 1'b0;
      ram2_ce_n  <= STROBE_OFF;
      ram2_oe_n  <= STROBE_OFF;
      ram2_we_n  <= STROBE_OFF;
      if_data    <= '0;
      mem_rdata  <= '0;
      if_ack     <= 1'b0;
      mem_ack    <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      cur_mem    <= cur_mem_nx;
      cur_we     <= cur_we_nx;
      ram2_addr  <= addr_nx;
      ram2_dq_o  <= dq_o_nx;
      ram2_dq_oe <= dq_oe_nx;
      ram2_ce_n  <= ce_n_nx;
      ram2_oe_n  <= oe_n_nx;
      ram2_we_n  <= we_n_nx;
      if_data    <= if_data_nx;
      mem_rdata  <= mem_rdata_nx;
      if_ack     <= if_ack_nx;
      mem_ack    <= mem_ack_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    cur_mem_nx   = cur_mem;
    cur_we_nx    = cur_we;
    addr_nx      = ram2_addr;
    dq_o_nx      = ram2_dq_o;
    dq_oe_nx     = ram2_dq_oe;
    ce_n_nx      = ram2_ce_n;
    oe_n_nx      = ram2_oe_n;
    we_n_nx      = ram2_we_n;
    if_data_nx   = if_data;
    mem_rdata_nx = mem_rdata;
    if_ack_nx    = 1'b0;
    mem_ack_nx   = 1'b0;
    unique case (state)
      R2_ACCESS: begin
        cnt_nx = cnt + 1'b1;
        if (cnt == CNT_LAST) begin
          state_nx = R2_RECOVER;
          oe_n_nx  = STROBE_OFF;
          we_n_nx  = STROBE_OFF;
          if (cur_mem) begin
            mem_ack_nx = 1'b1;
            if (!cur_we) mem_rdata_nx = ram2_dq_i;
          end else begin
            if_ack_nx  = 1'b1;
            if_data_nx = ram2_dq_i;
          end
        end
      end
      default: begin
        if (mem_go || (if_go && !ibuf_hit)) begin
          state_nx   = R2_ACCESS;
          cnt_nx     = '0;
          cur_mem_nx = mem_go;
          cur_we_nx  = mem_go && mem_we;
          addr_nx    = mem_go ? mem_addr : if_addr;
          ce_n_nx    = STROBE_ON;
          oe_n_nx    = strobe_level(!cur_we_nx);
          we_n_nx    = strobe_level(cur_we_nx);
          dq_oe_nx   = cur_we_nx;
          if (cur_we_nx) dq_o_nx = mem_wdata;
        end else begin
          // Reaching here with if_go set means a buffer hit: answer without an SRAM cycle.
          state_nx = R2_IDLE;
          ce_n_nx  = STROBE_OFF;
          dq_oe_nx = 1'b0;
          if (if_go) begin
            if_ack_nx  = 1'b1;
            if_data_nx = ibuf_data;
          end
        end
      end
    endcase
  end

endmodule

// File: tb/tb_ram2_arbiter.sv
// Randomized bench for ram2_arbiter with a transaction-level memory/latency model.
module tb_ram2_arbiter;

  localparam int W   = 2;
  localparam int LIM = 2 * W + 4;
`ifdef RAM2_IBUF_EN
  localparam bit IBUF = 1'b1;
`else
  localparam bit IBUF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0, mem_req = 1'b0, mem_we = 1'b0;
  logic [17:0] if_addr = '0, mem_addr = '0;
  logic [15:0] mem_wdata = '0;
  logic [15:0] if_data, mem_rdata, ram2_dq_o, ram2_dq_i;
  logic        if_ack, mem_ack, stall_req, ram2_dq_oe, ram2_ce_n, ram2_oe_n, ram2_we_n;
  logic [17:0] ram2_addr;

  logic [15:0] sram    [0:262143];
  logic [15:0] ref_mem [0:262143];
  bit          ib_valid = 1'b0;
  logic [17:0] ib_tag = '0;
  int          checks = 0, failures = 0, episodes = 0, run = 0;

  ram2_arbiter #(.ADDR_W(18), .DATA_W(16), .WAIT_CYC(W)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_data(if_data), .if_ack(if_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .stall_req(stall_req),
    .ram2_addr(ram2_addr), .ram2_dq_o(ram2_dq_o), .ram2_dq_i(ram2_dq_i),
    .ram2_dq_oe(ram2_dq_oe), .ram2_ce_n(ram2_ce_n), .ram2_oe_n(ram2_oe_n), .ram2_we_n(ram2_we_n)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] pat(input int a);
    return 16'(a * 40503 + 16'h1A5B);
  endfunction

  // SRAM environment: async read, writes on edges while CE/WE low and DQ driven.
  assign ram2_dq_i = sram[ram2_addr];
  initial begin
    for (int i = 0; i < 262144; i++) sram[i] = pat(i);
    sram[16] = 16'h6911;
    forever begin
      @(posedge clk);
      if (!ram2_ce_n && !ram2_we_n && ram2_dq_oe) sram[ram2_addr] = ram2_dq_o;
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Strobe monitor: every strobe episode lasts exactly W cycles, OE/WE never both low.
  always @(negedge clk) begin
    if (!rst) run = 0;
    else if (!ram2_oe_n || !ram2_we_n) begin
      run++;
      check("strobe_excl", int'(ram2_oe_n | ram2_we_n), 1);
    end else if (run != 0) begin
      check("strobe_len", run, W);
      episodes++;
      run = 0;
    end
  end

  // Called at a negedge with the DUT idle; drop_at>0 withdraws mem_req early.
  task automatic txn(input bit do_if, input logic [17:0] ia, input bit do_mem, input bit we,
                     input logic [17:0] ma, input logic [15:0] wd, input int drop_at);
    int if_lat = 0, mem_lat = 0, exp_eps, eps0;
    bit hit = 1'b0;
    logic [15:0] exp_if = '0, exp_mem = '0;
    if (do_mem) begin
      mem_lat = W + 1;
      if (we) begin
        ref_mem[ma] = wd;
        if (ib_tag == ma) ib_valid = 1'b0;
      end else exp_mem = ref_mem[ma];
    end
    if (do_if) begin
      hit    = IBUF && ib_valid && (ib_tag == ia);
      exp_if = ref_mem[ia];
      if (hit) if_lat = do_mem ? W + 2 : 1;
      else begin
        if_lat   = do_mem ? 2 * W + 2 : W + 1;
        ib_valid = 1'b1;
        ib_tag   = ia;
      end
    end
    exp_eps = int'(do_mem) + int'(do_if && !hit);
    eps0 = episodes;
    if_req = do_if; if_addr = ia;
    mem_req = do_mem; mem_we = we; mem_addr = ma; mem_wdata = wd;
    for (int i = 1; i <= LIM; i++) begin
      @(negedge clk);
      check("if_ack", int'(if_ack), int'(i == if_lat));
      check("mem_ack", int'(mem_ack), int'(i == mem_lat));
      check("stall_req", int'(stall_req),
            int'((do_if && i < if_lat) || (do_mem && i < mem_lat && (drop_at == 0 || i <= drop_at))));
      if (i == if_lat) begin
        check("if_data", int'(if_data), int'(exp_if));
        if_req = 1'b0;
      end
      if (i == mem_lat) begin
        if (!we) check("mem_rdata", int'(mem_rdata), int'(exp_mem));
        check("recover_dq_oe", int'(ram2_dq_oe), int'(we));
        check("recover_ce_n", int'(ram2_ce_n), 0);
        check("recover_addr", int'(ram2_addr), int'(ma));
        mem_req = 1'b0;
      end
      if (i == drop_at) mem_req = 1'b0;
    end
    check("sram_cycles", episodes - eps0, exp_eps);
  endtask

  function automatic logic [17:0] pick_addr();
    if ($urandom_range(0, 3) != 0) return 18'h40 + 18'($urandom_range(0, 3));
    return 18'($urandom_range(0, 'h3FEFF));
  endfunction

  initial begin
    for (int i = 0; i < 262144; i++) ref_mem[i] = pat(i);
    ref_mem[16] = 16'h6911;
    repeat (2) @(negedge clk);
    check("rst_ce_n", int'(ram2_ce_n), 1);
    check("rst_oe_n", int'(ram2_oe_n), 1);
    check("rst_we_n", int'(ram2_we_n), 1);
    check("rst_dq_oe", int'(ram2_dq_oe), 0);
    check("rst_acks", int'({if_ack, mem_ack}), 0);
    check("rst_addr", int'(ram2_addr), 0);
    check("rst_data", int'({if_data, mem_rdata, ram2_dq_o}), 0);
    rst = 1'b1;
    @(negedge clk);

    txn(1, 18'h00010, 0, 0, '0, '0, 0);                  // single read
    txn(0, '0, 1, 1, 18'h00003, 16'hE151, 0);            // store
    check("sram_store", int'(sram[3]), 'hE151);
    txn(0, '0, 1, 0, 18'h00003, '0, 0);                  // load back
    txn(1, 18'h00022, 1, 0, 18'h00020, '0, 0);           // collision
    txn(0, '0, 1, 0, 18'h00055, '0, 1);                  // request dropped mid-access
    txn(1, 18'h00040, 0, 0, '0, '0, 0);                  // fetch twice, store, fetch
    txn(1, 18'h00040, 0, 0, '0, '0, 0);
    txn(0, '0, 1, 1, 18'h00040, 16'hBEEF, 0);
    txn(1, 18'h00040, 0, 0, '0, '0, 0);
    txn(0, '0, 1, 1, 18'h3FFFF, 16'h5A5A, 0);            // top of address space
    txn(0, '0, 1, 0, 18'h3FFFF, '0, 0);

    // Reset in the middle of a write access.
    if_req = 1'b1; if_addr = 18'h00041;
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 18'h3FFF0; mem_wdata = 16'h1234;
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("midrst_ce_n", int'(ram2_ce_n), 1);
    check("midrst_oe_n", int'(ram2_oe_n), 1);
    check("midrst_we_n", int'(ram2_we_n), 1);
    check("midrst_dq_oe", int'(ram2_dq_oe), 0);
    check("midrst_acks", int'({if_ack, mem_ack}), 0);
    if_req = 1'b0; mem_req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    ib_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("postrst_acks", int'({if_ack, mem_ack}), 0);
      check("postrst_ce_n", int'(ram2_ce_n), 1);
    end

    for (int n = 0; n < 80; n++) begin
      int kind;
      logic [17:0] ia, ma;
      kind = int'($urandom_range(0, 3));
      ia = pick_addr();
      ma = pick_addr();
      case (kind)
        0: txn(1, ia, 0, 0, '0, '0, 0);
        1: txn(0, '0, 1, 1'($urandom_range(0, 1)), ma, 16'($urandom), 0);
        2: txn(1, ia, 1, 1'($urandom_range(0, 1)), ma, 16'($urandom), 0);
        default: txn(0, '0, 1, 1'($urandom_range(0, 1)), ma, 16'($urandom), 1);
      endcase
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
